// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/response/burst codes, burst length helper
// and the arbiter state encoding.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;
  localparam logic [1:0] HRESP_RETRY = 2'd2;
  localparam logic [1:0] HRESP_SPLIT = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Beats remaining after the NONSEQ; zero means no fixed length to hold for.
  function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_len_m1 = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len_m1 = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_len_m1 = 4'd15;
      default:                      burst_len_m1 = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first eligible index searching upward from rr_ptr+1 with wrap.
module rr_priority_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int MIDX_W      = 4
) (
  input  logic [NUM_MASTERS-1:0] eligible,
  input  logic [MIDX_W-1:0]      rr_ptr,
  output logic [MIDX_W-1:0]      winner,
  output logic                   valid
);

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (eligible[i] && (i == ((int'(rr_ptr) + off) % NUM_MASTERS))) begin
          winner = MIDX_W'(i);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin bus arbiter with fixed-burst hold, locked transfers and SPLIT masking.
//
// state  | meaning
// ARB    | grant re-evaluated on every hready=1 cycle
// BURST  | fixed-length burst in flight, grant held until last beat
// LOCKED | locked sequence in flight, grant held until hlock drops
module ahb_rr_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MIDX_W         = 4
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  input  logic [15:0]            hsplit,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MIDX_W-1:0]      hmaster,
  output logic                   hmastlock
);

  localparam logic [MIDX_W-1:0] DEF_IDX = MIDX_W'(DEFAULT_MASTER);

  arb_state_t               state;
  logic [NUM_MASTERS-1:0]   split_mask;
  logic [MIDX_W-1:0]        rr_ptr;
  logic [3:0]               beat_cnt;

  logic [NUM_MASTERS-1:0]   eligible;
  logic [MIDX_W-1:0]        winner;
  logic                     winner_valid;
  logic [MIDX_W-1:0]        next_idx;
  logic [NUM_MASTERS-1:0]   next_grant;
  logic [MIDX_W-1:0]        grant_idx;
  logic                     grant_lock;
  logic                     owner_lock;
  logic [NUM_MASTERS-1:0]   split_hit;
  logic                     split_evt;
  logic [3:0]               len_m1;
  logic                     unused_hsplit;

  assign eligible      = hbusreq & ~split_mask;
  assign next_idx      = winner_valid ? winner : DEF_IDX;
  assign grant_lock    = |(hlock & hgrant);
  assign split_evt     = !hready && (hresp == HRESP_SPLIT);
  assign len_m1        = burst_len_m1(hburst);
  assign unused_hsplit = ^hsplit;

  rr_priority_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .MIDX_W      (MIDX_W)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .winner   (winner),
    .valid    (winner_valid)
  );

  // Index decode/encode kept as loops so no variable-width bit selects appear.
  always_comb begin
    grant_idx  = '0;
    owner_lock = 1'b0;
    next_grant = '0;
    split_hit  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant[i]) grant_idx = MIDX_W'(i);
      if (MIDX_W'(i) == hmaster) begin
        owner_lock = hlock[i];
        if (i != DEFAULT_MASTER) split_hit[i] = 1'b1;
      end
      next_grant[i] = (MIDX_W'(i) == next_idx);
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant     <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      hmaster    <= DEF_IDX;
      hmastlock  <= 1'b0;
      split_mask <= '0;
      rr_ptr     <= DEF_IDX;
      beat_cnt   <= '0;
      state      <= ARB;
    end else begin
      // A SPLIT set in the same cycle as its release overrides the release.
      split_mask <= (split_mask & ~hsplit[NUM_MASTERS-1:0]) | (split_evt ? split_hit : '0);
      if (!hready) begin
        if (split_evt) state <= ARB;
      end else begin
        hmaster   <= grant_idx;
        hmastlock <= grant_lock;
        case (state)
          ARB: begin
            if (htrans == HTRANS_NONSEQ && len_m1 != 4'd0) begin
              state    <= BURST;
              beat_cnt <= len_m1;
            end else if (htrans == HTRANS_NONSEQ && owner_lock) begin
              state <= LOCKED;
            end else begin
              hgrant <= next_grant;
              if (winner_valid) rr_ptr <= winner;
            end
          end
          BURST: begin
            if (htrans == HTRANS_IDLE || htrans == HTRANS_NONSEQ ||
                (htrans == HTRANS_SEQ && beat_cnt <= 4'd1)) begin
              state    <= ARB;
              beat_cnt <= '0;
              hgrant   <= next_grant;
              if (winner_valid) rr_ptr <= winner;
            end else if (htrans == HTRANS_SEQ) begin
              beat_cnt <= beat_cnt - 4'd1;
            end
          end
          LOCKED: begin
            if (!owner_lock) state <= ARB;
          end
          default: state <= ARB;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: vector table plus split and reset sequences.
module tb_ahb_rr_arbiter;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [3:0]  hbusreq;
  logic [3:0]  hlock;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic        hready;
  logic [1:0]  hresp;
  logic [15:0] hsplit;
  logic [3:0]  hgrant;
  logic [3:0]  hmaster;
  logic        hmastlock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic [3:0] g;
    logic [3:0] m;
    logic       l;
  } vec_t;

  vec_t vecs[$];

  ahb_rr_arbiter #(
    .NUM_MASTERS    (4),
    .DEFAULT_MASTER (0),
    .MIDX_W         (4)
  ) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hsplit    (hsplit),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] lock, logic [1:0] trans,
                              logic [2:0] burst, logic rdy, logic [3:0] g, logic [3:0] m, logic l);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.trans = trans; v.burst = burst;
    v.rdy = rdy; v.g = g; v.m = m; v.l = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1ns later.
  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                      input logic [1:0] trans, input logic [2:0] burst, input logic rdy,
                      input logic [1:0] resp, input logic [15:0] split);
    hreset = rst; hbusreq = req; hlock = lock; htrans = trans; hburst = burst;
    hready = rdy; hresp = resp; hsplit = split;
    @(posedge hclk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] m, input logic l);
    check({tag, " hgrant"}, 16'(hgrant), 16'(g));
    check({tag, " hmaster"}, 16'(hmaster), 16'(m));
    check({tag, " hmastlock"}, 16'(hmastlock), 16'(l));
  endtask

  initial begin
    hreset = 1'b1; hbusreq = '0; hlock = '0; htrans = HTRANS_IDLE; hburst = HBURST_SINGLE;
    hready = 1'b1; hresp = HRESP_OKAY; hsplit = '0;

    // reset then idle: default master keeps the bus
    vecs.push_back(mk(1, 4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, 4'b0001, 4'd0, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, 4'b0001, 4'd0, 0));
    // all request, single transfers: rotation with hmaster one cycle behind
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1, 4'b0010, 4'd0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1, 4'b0100, 4'd1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1, 4'b1000, 4'd2, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1, 4'b0001, 4'd3, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1, 4'b0010, 4'd0, 0));
    // master 1 INCR4 with a stall on beat 2; grant moves on the last beat
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1, 4'b0010, 4'd1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_SEQ,    HBURST_INCR4, 1, 4'b0010, 4'd1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_SEQ,    HBURST_INCR4, 0, 4'b0010, 4'd1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_SEQ,    HBURST_INCR4, 1, 4'b0010, 4'd1, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_SEQ,    HBURST_INCR4, 1, 4'b0100, 4'd1, 0));
    // master 2 takes the bus alone, then locks through 6 transfers under contention
    vecs.push_back(mk(0, 4'b0100, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1, 4'b0100, 4'd2, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, HTRANS_NONSEQ, HBURST_SINGLE, 1, 4'b0100, 4'd2, 1));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(0, 4'b1111, 4'b0100, HTRANS_NONSEQ, HBURST_SINGLE, 1, 4'b0100, 4'd2, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1, 4'b0100, 4'd2, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1, 4'b1000, 4'd2, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].trans, vecs[i].burst,
           vecs[i].rdy, HRESP_OKAY, 16'h0000);
      expect_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].m, vecs[i].l);
    end

    // SPLIT of master 3: masked, default granted, released by hsplit[3]
    step(0, 4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, HRESP_OKAY, 16'h0000);
    expect_out("split_own", 4'b1000, 4'd3, 0);
    step(0, 4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 0, HRESP_SPLIT, 16'h0000);
    expect_out("split_c1", 4'b1000, 4'd3, 0);
    step(0, 4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, HRESP_SPLIT, 16'h0000);
    expect_out("split_c2", 4'b0001, 4'd3, 0);
    step(0, 4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, HRESP_OKAY, 16'h0000);
    expect_out("split_masked", 4'b0001, 4'd0, 0);
    step(0, 4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, HRESP_OKAY, 16'h0008);
    step(0, 4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, HRESP_OKAY, 16'h0000);
    expect_out("split_release", 4'b1000, 4'd0, 0);

    // reset in the middle of an INCR8: no burst hold survives
    step(0, 4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, HRESP_OKAY, 16'h0000);
    expect_out("incr8_own", 4'b1000, 4'd3, 0);
    step(0, 4'b1000, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1, HRESP_OKAY, 16'h0000);
    expect_out("incr8_b1", 4'b1000, 4'd3, 0);
    for (int k = 2; k <= 4; k++) begin
      step(0, 4'b1111, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1, HRESP_OKAY, 16'h0000);
      expect_out($sformatf("incr8_b%0d", k), 4'b1000, 4'd3, 0);
    end
    step(1, 4'b1111, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1, HRESP_OKAY, 16'h0000);
    expect_out("rst_mid", 4'b0001, 4'd0, 0);
    step(0, 4'b1111, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1, HRESP_OKAY, 16'h0000);
    expect_out("post_rst1", 4'b0010, 4'd0, 0);
    step(0, 4'b1111, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1, HRESP_OKAY, 16'h0000);
    expect_out("post_rst2", 4'b0100, 4'd1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
- Central AHB bus arbiter for the four-master system. It shares the single address/data bus between ahb_master instances.
- Decides which master owns the bus using fair round-robin, with lock, fixed-length burst and SPLIT support.
- Drives hgrant to the masters, and hmaster/hmastlock to master_multiplexer and the slaves.
- Consumes the muxed bus htrans/hburst, the selected slave's hready/hresp, and the OR of all slave hsplit vectors.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- DEFAULT_MASTER, 0, index granted when no master requests.
- MIDX_W, 4, width of hmaster.

Ports:
- hclk  in  1  bus clock; all state updates on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hbusreq  in  NUM_MASTERS  per-master bus request.
- hlock  in  NUM_MASTERS  per-master locked-transfer request.
- htrans  in  2  muxed bus transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst  in  3  muxed bus burst type.
- hready  in  1  selected slave ready (slave_multiplexer output).
- hresp  in  2  selected slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
- hsplit  in  16  OR of slave split-release vectors; bit i releases master i.
- hgrant  out  NUM_MASTERS  one-hot grant; exactly one bit set after reset.
- hmaster  out  MIDX_W  index of master owning the current address phase.
- hmastlock  out  1  current address phase is locked.

Behaviour:
- Reset (hreset=1 at posedge):
  - hgrant = one-hot(DEFAULT_MASTER), hmaster = DEFAULT_MASTER, hmastlock = 0.
  - split_mask = 0, rr_ptr = DEFAULT_MASTER, beat_cnt = 0, state = ARB.
  - Reset mid-burst or mid-lock aborts immediately; there is no pending state.
- Eligible set: eligible = hbusreq & ~split_mask.
- Winner: first set bit of eligible, searching from (rr_ptr+1) mod NUM_MASTERS upward with wrap. If eligible is empty, the winner is DEFAULT_MASTER.
- Grant/ownership timing:
  - hgrant is registered and may change only on a cycle where hready=1 and state=ARB.
  - On a handover edge: hmaster <= index of the previous hgrant; hmastlock <= hlock[that index].
  - Result: address-phase ownership lags hgrant by exactly one hready cycle.
  - hready=0 freezes hgrant, hmaster, hmastlock, beat_cnt and state.
  - rr_ptr <= winner whenever a new grant is issued to a requesting master. Default grants do not move rr_ptr.
- State machine:
  - ARB: re-arbitrate on each hready=1 cycle.
    - Go to BURST if hready=1, htrans=NONSEQ and hburst is INCR4/WRAP4 (2,3), INCR8/WRAP8 (4,5) or INCR16/WRAP16 (6,7). Load beat_cnt = len-1 (3, 7 or 15).
    - Go to LOCKED if hlock[hmaster]=1 and htrans=NONSEQ.
  - BURST: grant held.
    - Decrement beat_cnt on hready=1 with htrans=SEQ. BUSY holds the count.
    - Return to ARB when beat_cnt reaches 0 with hready=1, or on htrans=IDLE/NONSEQ (early termination).
    - Re-arbitration is allowed on the final beat's hready edge.
  - LOCKED: grant held regardless of other requests. Exit to ARB on the first hready=1 cycle where hlock[hmaster]=0.
  - SINGLE/INCR bursts (hburst 0/1) stay in ARB. An undefined-length INCR may lose the bus at any hready edge.
- SPLIT handling:
  - On hready=0 with hresp=SPLIT (first cycle of the two-cycle response), set split_mask[hmaster] and force state=ARB.
  - The next hready edge re-arbitrates excluding that master.
  - split_mask[i] clears on any cycle where hsplit[i]=1. If set and clear occur in the same cycle, set wins.
  - The DEFAULT_MASTER bit is never masked: a SPLIT to the default master is ignored for masking.
- RETRY/ERROR: no arbitration effect; the state machine continues normally.
- Grant is never given to a masked master, including when it would otherwise be the default.
- Simultaneous requests: the rr_ptr rotation guarantees each persistent requester is granted within NUM_MASTERS handovers.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_* and HRESP_* constants;
  - HBURST_* codes;
  - a burst-length function (hburst to beat count minus 1);
  - the arbiter state enum {ARB, BURST, LOCKED}.
  - master_multiplexer, ahb_slave and ahb_master use the same package.
- One sub-module: rr_priority_pick (combinational; inputs eligible vector and rr_ptr, outputs winner index and valid).

Test Plan:
- Reset with hbusreq=0000 -> hgrant=0001, hmaster=0, hmastlock=0. Still holds after 5 idle cycles.
- hbusreq=1111 held, hready=1, htrans=NONSEQ, hburst=SINGLE -> hgrant sequence 0010, 0100, 1000, 0001 repeating. hmaster follows one cycle behind.
- Master 1 granted, NONSEQ INCR4 then 3 SEQ beats; insert one hready=0 cycle on beat 2; hbusreq=1111 -> hgrant stays 0010 for all 4 beats plus the stall, then moves to 0100.
- Master 2 with hlock[2]=1 across 6 transfers while others request -> hgrant=0100 and hmastlock=1 throughout. Grant moves one hready edge after hlock[2] drops.
- Master 3 owns the bus; hresp=SPLIT (hready=0 then 1); hbusreq=1000 only -> hgrant=0001 (default). Pulse hsplit[3]=1 -> master 3 re-granted at the next hready edge.
- hreset asserted mid-INCR8 at beat 4 -> the next edge gives hgrant=0001, state ARB, split_mask=0, and no burst hold afterwards.
